// File: rtl/apb_reg_responder.sv
// APB register responder: an ID register at word 0 plus byte-strobed RW
// registers, with a configurable number of wait states per access phase.
module apb_reg_responder #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_cfg_in_m_paddr_0,
  input  logic        m_cfg_in_m_psel_0,
  input  logic        m_cfg_in_m_penable_0,
  input  logic        m_cfg_in_m_pwrite_0,
  input  logic [31:0] m_cfg_in_m_pwdata_0,
  input  logic [3:0]  m_cfg_in_m_pstrb_0,
  output logic        m_cfg_out_m_pready_0,
  output logic [31:0] m_cfg_out_m_prdata_0,
  output logic        m_cfg_out_m_pslverr_0
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

  localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);
  localparam logic [4:0] LP_NUM  = 5'(NUM_REGS);

  state_t      r_state;
  logic [2:0]  r_waitCnt;
  logic [3:0]  r_idx;
  logic        r_write;
  logic        r_err;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_rdVal;
  logic        r_pready;
  logic        r_pslverr;
  logic [31:0] r_prdata;
  // Sized to the full 4-bit index so any decoded index is in range;
  // entries at or above NUM_REGS are never written and stay zero.
  logic [31:0] r_regs [16];

  logic [3:0]  w_idx;
  logic        w_err;
  logic [31:0] w_rdVal;

  // Address decode and read-data selection from the live setup-phase bus
  always_comb begin
    w_idx   = m_cfg_in_m_paddr_0[5:2];
    w_err   = (m_cfg_in_m_paddr_0[1:0] != 2'b00) ||
              (m_cfg_in_m_paddr_0[31:6] != 26'd0) ||
              ({1'b0, w_idx} >= LP_NUM) ||
              (m_cfg_in_m_pwrite_0 && (w_idx == 4'd0));
    w_rdVal = 32'd0;
    if (!w_err && !m_cfg_in_m_pwrite_0) begin
      w_rdVal = (w_idx == 4'd0) ? ID_VALUE : r_regs[w_idx];
    end
  end

  // Transfer FSM with registered response outputs and register-file commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_waitCnt <= 3'd0;
      r_idx     <= 4'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= 32'd0;
      r_strb    <= 4'd0;
      r_rdVal   <= 32'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (m_cfg_in_m_psel_0 && !m_cfg_in_m_penable_0) begin
            r_state   <= SETUP;
            r_waitCnt <= LP_WAIT;
          end
        end
        SETUP: begin
          r_idx   <= w_idx;
          r_write <= m_cfg_in_m_pwrite_0;
          r_err   <= w_err;
          r_wdata <= m_cfg_in_m_pwdata_0;
          r_strb  <= m_cfg_in_m_pstrb_0;
          r_rdVal <= w_rdVal;
          if (WAIT_STATES > 0) begin
            r_state <= WAIT;
          end else begin
            r_state   <= RESP;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_rdVal;
          end
        end
        WAIT: begin
          if (!m_cfg_in_m_psel_0) begin
            r_state   <= IDLE;
            r_waitCnt <= 3'd0;
          end else if (r_waitCnt <= 3'd1) begin
            r_state   <= RESP;
            r_waitCnt <= 3'd0;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= r_rdVal;
          end else begin
            r_waitCnt <= r_waitCnt - 3'd1;
          end
        end
        RESP: begin
          if (r_write && !r_err) begin
            for (int b = 0; b < 4; b++) begin
              if (r_strb[b]) begin
                r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
              end
            end
          end
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= 32'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_cfg_out_m_pready_0  = r_pready;
  assign m_cfg_out_m_prdata_0  = r_prdata;
  assign m_cfg_out_m_pslverr_0 = r_pslverr;

endmodule

// File: tb/tb_apb_reg_responder.sv
// Scoreboard bench for apb_reg_responder: three instances with 0, 1 and 7
// wait states share one reset and are exercised one transfer at a time.
module tb_apb_reg_responder;

  localparam int          NUM = 8;
  localparam logic [31:0] ID  = 32'hA5B0_0001;

  logic        clk;
  logic        rst;
  logic [2:0]  psel;
  logic [2:0]  penable;
  logic [2:0]  pwrite;
  logic [31:0] paddr  [3];
  logic [31:0] pwdata [3];
  logic [3:0]  pstrb  [3];
  wire  [2:0]  pready;
  wire  [2:0]  pslverr;
  wire  [31:0] prdata [3];

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          startCyc;
  } expT;

  expT         expQ[$];
  logic [31:0] mdl [3][16];
  int          cyc;
  int          total;
  int          bad;

  for (genvar g = 0; g < 3; g++) begin : gDut
    apb_reg_responder #(
      .NUM_REGS   (NUM),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 7)),
      .ID_VALUE   (ID)
    ) uDut (
      .clk                  (clk),
      .rst                  (rst),
      .m_cfg_in_m_paddr_0   (paddr[g]),
      .m_cfg_in_m_psel_0    (psel[g]),
      .m_cfg_in_m_penable_0 (penable[g]),
      .m_cfg_in_m_pwrite_0  (pwrite[g]),
      .m_cfg_in_m_pwdata_0  (pwdata[g]),
      .m_cfg_in_m_pstrb_0   (pstrb[g]),
      .m_cfg_out_m_pready_0 (pready[g]),
      .m_cfg_out_m_prdata_0 (prdata[g]),
      .m_cfg_out_m_pslverr_0(pslverr[g])
    );
  end

  // Free-running clock and cycle counter used for latency measurement
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 7);
  endfunction

  // Reference rules: word aligned, inside the 64-byte window, below NUM
  // words, and word 0 is read-only.
  function automatic logic modelErr(input logic [31:0] addr, input logic wr);
    return (addr % 4 != 0) || (addr >= 64) || (addr / 4 >= NUM) ||
           (wr && (addr / 4 == 0));
  endfunction

  function automatic logic [31:0] modelRead(input int d, input logic [31:0] addr);
    if (addr / 4 == 0) return ID;
    return mdl[d][addr / 4];
  endfunction

  task automatic modelWrite(input int d, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mdl[d][addr / 4][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic modelClear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pready pulse, otherwise checks idle outputs
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (pready[d]) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL spurious_pready: got pready=1 on dut %0d expected none", d);
          end else begin
            expT e;
            e = expQ.pop_front();
            checkOutput("resp_dut", d, e.dut);
            checkOutput("resp_prdata", prdata[d], e.data);
            checkOutput("resp_pslverr", {31'd0, pslverr[d]}, {31'd0, e.err});
            checkOutput("resp_latency", cyc - e.startCyc, e.lat);
          end
        end else begin
          checkOutput("idle_prdata", prdata[d], 32'd0);
          checkOutput("idle_pslverr", {31'd0, pslverr[d]}, 32'd0);
        end
      end
    end
  end

  task automatic checkOutputsZero(input int d, input string tag);
    checkOutput({tag, "_pready"}, {31'd0, pready[d]}, 32'd0);
    checkOutput({tag, "_prdata"}, prdata[d], 32'd0);
    checkOutput({tag, "_pslverr"}, {31'd0, pslverr[d]}, 32'd0);
  endtask

  // mode 0: normal, 1: reset during the response cycle,
  // 2: reset during wait states, 3: psel dropped during wait states
  task automatic applyStimulus(input int d, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int mode);
    expT  e;
    logic err;
    logic seen;
    err = modelErr(addr, wr);
    @(posedge clk);
    #1;
    paddr[d]   = addr;
    pwrite[d]  = wr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    e.dut      = d;
    e.data     = (wr || err) ? 32'd0 : modelRead(d, addr);
    e.err      = err;
    e.lat      = wsOf(d) + 2;
    e.startCyc = cyc;
    if (mode <= 1) expQ.push_back(e);
    @(posedge clk);
    #1 penable[d] = 1'b1;
    if (mode <= 1) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (pready[d]) seen = 1'b1;
      end
      checkOutput("pready_seen", {31'd0, seen}, 32'd1);
      if (mode == 1) begin
        #2 rst = 1'b0;
        #1 checkOutputsZero(d, "rst_resp");
        modelClear();
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        #10 rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (wr && !err) modelWrite(d, addr, wdata, strb);
      end
    end else begin
      repeat (3) @(negedge clk);
      if (mode == 2) begin
        #2 rst = 1'b0;
        #1 checkOutputsZero(d, "rst_wait");
        modelClear();
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        #10 rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
          @(negedge clk);
          if (pready[d]) seen = 1'b1;
        end
        checkOutput("abort_no_pready", {31'd0, seen}, 32'd0);
      end
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // psel with penable already high while idle must be ignored
  task automatic protoViolation(input int d);
    logic seen;
    @(posedge clk);
    #1;
    paddr[d]   = 32'd0;
    pwrite[d]  = 1'b0;
    psel[d]    = 1'b1;
    penable[d] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[d]) seen = 1'b1;
    end
    checkOutput("violation_no_pready", {31'd0, seen}, 32'd0);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by randomized traffic
  initial begin
    logic [31:0] addr;
    int          d;
    int          kind;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    psel  = 3'd0;
    penable = 3'd0;
    pwrite  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      paddr[i]  = 32'd0;
      pwdata[i] = 32'd0;
      pstrb[i]  = 4'd0;
    end
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) checkOutputsZero(i, "reset");
    rst = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(i, 32'h0, 1'b0, 32'd0, 4'h0, 0);

    applyStimulus(1, 32'h4, 1'b1, 32'h1234_5678, 4'hF, 0);
    applyStimulus(1, 32'h4, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'h8, 1'b1, 32'hFFFF_FFFF, 4'h5, 0);
    applyStimulus(1, 32'h8, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'h0, 1'b1, 32'h5555_AAAA, 4'hF, 0);
    applyStimulus(1, 32'h20, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'h6, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'h0, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'h0, 0);
    applyStimulus(1, 32'h4, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(0, 32'h1C, 1'b1, 32'h0BAD_F00D, 4'hC, 0);
    applyStimulus(0, 32'h1C, 1'b0, 32'd0, 4'h0, 0);

    protoViolation(1);

    applyStimulus(2, 32'h10, 1'b1, 32'hCAFE_F00D, 4'hF, 3);
    applyStimulus(2, 32'h10, 1'b0, 32'd0, 4'h0, 0);

    applyStimulus(2, 32'hC, 1'b1, 32'hDEAD_BEEF, 4'hF, 2);
    applyStimulus(2, 32'hC, 1'b0, 32'd0, 4'h0, 0);

    applyStimulus(1, 32'hC, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    applyStimulus(1, 32'h14, 1'b1, 32'hDEAD_BEEF, 4'hF, 1);
    applyStimulus(1, 32'h14, 1'b0, 32'd0, 4'h0, 0);
    applyStimulus(1, 32'hC, 1'b0, 32'd0, 4'h0, 0);

    for (int n = 0; n < 80; n++) begin
      d    = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      addr = {26'd0, 4'($urandom_range(0, 9)), 2'b00};
      if (kind == 7) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 8) addr = addr | 32'(32'h40 << $urandom_range(0, 25));
      applyStimulus(d, addr, 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), 0);
    end

    repeat (3) @(posedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_responder.md
APB_REG_RESPONDER -- requirements
Module: apb_reg_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the number of 32-bit word registers; legal range 2..16.
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the number of PREADY-low cycles in each access phase; legal range 0..7.
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, meaning the read-only value of register 0.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state changes on rising edge
  rst  input  1  reset, asynchronous assert, active-low
  m_cfg_in_m_paddr_0  input  32  APB byte address
  m_cfg_in_m_psel_0  input  1  APB select
  m_cfg_in_m_penable_0  input  1  APB enable (access phase)
  m_cfg_in_m_pwrite_0  input  1  1=write, 0=read
  m_cfg_in_m_pwdata_0  input  32  write data
  m_cfg_in_m_pstrb_0  input  4  byte write strobes
  m_cfg_out_m_pready_0  output  1  transfer complete
  m_cfg_out_m_prdata_0  output  32  read data
  m_cfg_out_m_pslverr_0  output  1  transfer error
REQ-005 SHALL use one clock, clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, WAIT, RESP.
REQ-007 IDLE->SETUP when psel=1 and penable=0; psel=1 with penable=1 in IDLE SHALL be ignored (protocol violation, stays IDLE).
REQ-008 SETUP SHALL latch paddr, pwrite, pwdata, pstrb and decode; next state WAIT if WAIT_STATES>0, else RESP.
REQ-009 WAIT SHALL count WAIT_STATES cycles with pready=0, then go to RESP.
REQ-010 RESP SHALL assert pready=1 for exactly one cycle with valid prdata/pslverr, then go to IDLE; back-to-back: if psel=1 and penable=0 in that cycle's following sample, IDLE->SETUP as normal.
REQ-011 pready, pslverr SHALL be 0 and prdata SHALL be 0 in every cycle outside RESP.
REQ-012 Index = paddr[5:2]; decode error when paddr[1:0]!=0, index>=NUM_REGS, or paddr[31:6]!=0.
REQ-013 Register 0 SHALL read ID_VALUE; a write to register 0 SHALL set pslverr=1 and change nothing.
REQ-014 Registers 1..NUM_REGS-1 SHALL be read/write; a write SHALL update byte lane n only where pstrb[n]=1, committed on the RESP cycle edge.
REQ-015 pstrb=4'h0 write to a valid RW register SHALL complete with pslverr=0 and no change.
REQ-016 Errored reads SHALL return prdata=0; errored writes SHALL not modify any register.
REQ-017 Reads SHALL return register contents as of the SETUP latch; a read SHALL never alter state.
REQ-018 psel dropping during WAIT (aborted transfer) SHALL return FSM to IDLE next cycle with no register write and no pready pulse.
REQ-019 Wait counter SHALL be 3 bits, reloaded on every SETUP entry; no wrap beyond WAIT_STATES.

Reset
REQ-020 rst=0 SHALL immediately force IDLE, pready=0, pslverr=0, prdata=0, wait counter 0, and all RW registers to 32'h0, independent of clk.
REQ-021 Reset asserted mid-transfer SHALL abort it with no write committed; after rst=1 the block SHALL accept a new SETUP on the first following rising edge.

Verification
REQ-022 After reset, read addr 0x0 -> prdata=32'hA5B00001, pslverr=0, pready high exactly WAIT_STATES+2 cycles after psel rise.
REQ-023 Write 0x4 = 32'h12345678 pstrb=4'hF, then read 0x4 -> 32'h12345678, pslverr=0 on both.
REQ-024 Write 0x8 = 32'hFFFFFFFF pstrb=4'h5 over 0 -> read 0x8 returns 32'h00FF00FF.
REQ-025 Write 0x0, read 0x20 (NUM_REGS=8), read 0x6 -> pslverr=1 each; reads return 0; register 0 still reads ID_VALUE.
REQ-026 Sweep WAIT_STATES 0 and 7 -> pready low exactly 0 and 7 access-phase cycles; psel dropped in WAIT -> no pready, target register unchanged.
REQ-027 Assert rst=0 mid-write to 0xC of 32'hDEADBEEF -> outputs 0 asynchronously; subsequent read 0xC -> 32'h0.
